// File: rtl/range_ctrl_if.sv
// ----------------------------------------------------------------------------
// range_ctrl_if
// Link between the range_ctrl sequencer and the `range` Collatz datapath.
//
// Signals:
//   go     launch pulse (sequencer -> datapath)
//   start  32-bit start value for the run (sequencer -> datapath)
//   done   run complete, level (datapath -> sequencer)
//   n      result RAM read address (sequencer -> datapath)
//   count  iteration count read from the RAM at n (datapath -> sequencer)
//
// Modports:
//   master  sequencer side (range_ctrl)
//   slave   datapath side (range)
// ----------------------------------------------------------------------------
interface range_ctrl_if #(
  parameter int RAM_ADDR_BITS = 8
);
  logic                     go;
  logic [31:0]              start;
  logic                     done;
  logic [RAM_ADDR_BITS-1:0] n;
  logic [15:0]              count;

  modport master (output go, start, n, input done, count);
  modport slave  (input go, start, n, output done, count);
endinterface

// File: rtl/range_ctrl.sv
// ----------------------------------------------------------------------------
// range_ctrl
// User-facing sequencer for the `range` Collatz datapath. Debounces the four
// pushbuttons, latches the start seed from the switches, launches a run,
// waits for completion and lets the user browse the result RAM.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   key_n[3:0]  raw active-low pushbuttons: [0]=go [1]=inc [2]=dec [3]=clear
//   sw[9:0]     start seed
//   bus         range_ctrl_if.master: go/start/n out, done/count in
//   disp_value  start[11:0] + n, modulo 4096
//   disp_count  iteration count latched for the displayed offset
//   busy        high while launching, running or fetching
//   valid       high while a result is being shown
//
// Optional build macro:
//   HOLD_REPEAT_EN  holding inc/dec while browsing generates repeat steps
//                   after REPEAT_DELAY cycles, then every REPEAT_PERIOD.
// ----------------------------------------------------------------------------
module range_ctrl #(
  parameter int RAM_WORDS       = 256,
  parameter int RAM_ADDR_BITS   = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw,
  range_ctrl_if.master bus,
  output logic [11:0] disp_value,
  output logic [15:0] disp_count,
  output logic        busy,
  output logic        valid
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Timing parameters that cannot produce a working repeat/debounce schedule
  // are rejected at elaboration.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("range_ctrl: invalid timing parameters");
  end

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, FETCH, SHOW} state_t;

  state_t                   state_reg, state_next;
  logic [RAM_ADDR_BITS-1:0] n_reg, n_next;
  logic [9:0]               start_reg, start_next;
  logic [15:0]              disp_count_reg, disp_count_next;
  logic                     fetch_cnt_reg, fetch_cnt_next;

  logic [3:0] key_down;        // debounced level, 1 = pressed
  logic [3:0] key_down_d_reg;
  logic [3:0] press;           // one-cycle pulse on released->pressed
  logic [1:0] repeat_ev;       // [0]=inc repeat, [1]=dec repeat
  logic       ev_go, ev_clear, ev_inc, ev_dec;

  genvar gi;

  // --------------------------------------------------------------------------
  // Key path: 2-FF synchronizer, then a stability counter that only moves the
  // debounced level after DEBOUNCE_CYCLES consecutive samples disagree with it.
  // Reset loads the "released" level everywhere so reset release is silent.
  // --------------------------------------------------------------------------
  for (gi = 0; gi < 4; gi++) begin : g_key
    logic            sync1_reg, sync2_reg;
    logic            down_reg;
    logic [DB_W-1:0] stable_cnt_reg;
    logic            sample_down;

    assign sample_down = ~sync2_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_reg      <= 1'b1;
        sync2_reg      <= 1'b1;
        down_reg       <= 1'b0;
        stable_cnt_reg <= '0;
      end else begin
        sync1_reg <= key_n[gi];
        sync2_reg <= sync1_reg;
        if (sample_down == down_reg) begin
          stable_cnt_reg <= '0;
        end else if (stable_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          down_reg       <= sample_down;
          stable_cnt_reg <= '0;
        end else begin
          stable_cnt_reg <= stable_cnt_reg + DB_W'(1);
        end
      end
    end

    assign key_down[gi] = down_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) key_down_d_reg <= 4'b0000;
    else       key_down_d_reg <= key_down;
  end

  assign press = key_down & ~key_down_d_reg;

`ifdef HOLD_REPEAT_EN
  // --------------------------------------------------------------------------
  // Auto-repeat for inc/dec. The counter keeps running through the FETCH
  // cycles that each step causes, so a steady hold yields a steady cadence;
  // it clears on release or when the browse loop (SHOW/FETCH) is left.
  // After the first repeat the counter reloads so the next one is
  // REPEAT_PERIOD cycles away.
  // --------------------------------------------------------------------------
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

  logic browsing;
  assign browsing = (state_reg == SHOW) || (state_reg == FETCH);

  for (gi = 0; gi < 2; gi++) begin : g_rpt
    logic [RPT_W-1:0] hold_cnt_reg;
    logic             rpt_reg;

    always_ff @(posedge clk) begin
      if (reset || !browsing || !key_down[gi+1]) begin
        hold_cnt_reg <= '0;
        rpt_reg      <= 1'b0;
      end else if (hold_cnt_reg == RPT_W'(REPEAT_DELAY - 1)) begin
        hold_cnt_reg <= RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
        rpt_reg      <= 1'b1;
      end else begin
        hold_cnt_reg <= hold_cnt_reg + RPT_W'(1);
        rpt_reg      <= 1'b0;
      end
    end

    assign repeat_ev[gi] = rpt_reg;
  end
`else
  assign repeat_ev = 2'b00;
`endif

  assign ev_go    = press[0];
  assign ev_clear = press[3];
  assign ev_inc   = press[1] | repeat_ev[0];
  assign ev_dec   = press[2] | repeat_ev[1];

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      n_reg          <= '0;
      start_reg      <= '0;
      disp_count_reg <= '0;
      fetch_cnt_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      n_reg          <= n_next;
      start_reg      <= start_next;
      disp_count_reg <= disp_count_next;
      fetch_cnt_reg  <= fetch_cnt_next;
    end
  end

  // The seed and n are loaded on the way into LAUNCH so that start is already
  // stable during the cycle in which go is presented to the datapath.
  always_comb begin
    state_next      = state_reg;
    n_next          = n_reg;
    start_next      = start_reg;
    disp_count_next = disp_count_reg;
    fetch_cnt_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ev_go) begin
          state_next = LAUNCH;
          start_next = sw;
          n_next     = '0;
        end
      end
      LAUNCH: state_next = RUN;
      RUN: begin
        if (bus.done) state_next = FETCH;
      end
      FETCH: begin
        // Two cycles: n settles into the RAM, then the registered read
        // data is valid and gets latched.
        if (fetch_cnt_reg) begin
          disp_count_next = bus.count;
          state_next      = SHOW;
        end else begin
          fetch_cnt_next = 1'b1;
        end
      end
      SHOW: begin
        if (ev_go) begin
          state_next = LAUNCH;
          start_next = sw;
          n_next     = '0;
        end else if (ev_clear) begin
          n_next     = '0;
          state_next = FETCH;
        end else if (ev_inc) begin
          n_next     = (n_reg == RAM_ADDR_BITS'(RAM_WORDS - 1)) ? '0 : n_reg + RAM_ADDR_BITS'(1);
          state_next = FETCH;
        end else if (ev_dec) begin
          n_next     = (n_reg == '0) ? RAM_ADDR_BITS'(RAM_WORDS - 1) : n_reg - RAM_ADDR_BITS'(1);
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.go     = (state_reg == LAUNCH);
  assign bus.start  = {22'b0, start_reg};
  assign bus.n      = n_reg;
  assign busy       = (state_reg == LAUNCH) || (state_reg == RUN) || (state_reg == FETCH);
  assign valid      = (state_reg == SHOW);
  assign disp_count = disp_count_reg;
  assign disp_value = {2'b00, start_reg} + 12'(n_reg);

endmodule

// File: tb/tb_range_ctrl.sv
// ----------------------------------------------------------------------------
// tb_range_ctrl
// Directed + randomized bench for range_ctrl. The bench plays the `range`
// datapath (random result RAM with a registered read) and predicts n,
// disp_value and disp_count from the user-level rules: wrap-around stepping,
// clear to zero, start+n modulo 4096, and count = RAM[n].
// ----------------------------------------------------------------------------
module tb_range_ctrl;

  localparam int RAM_WORDS = 256;
  localparam int ADDR_BITS = 8;
  localparam int DB_CYC    = 4;
  localparam int RPT_DLY   = 20;
  localparam int RPT_PER   = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic [9:0]  sw    = '0;
  logic [11:0] disp_value;
  logic [15:0] disp_count;
  logic        busy;
  logic        valid;

  range_ctrl_if #(.RAM_ADDR_BITS(ADDR_BITS)) bus ();

  range_ctrl #(
    .RAM_WORDS      (RAM_WORDS),
    .RAM_ADDR_BITS  (ADDR_BITS),
    .DEBOUNCE_CYCLES(DB_CYC),
    .REPEAT_DELAY   (RPT_DLY),
    .REPEAT_PERIOD  (RPT_PER)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .sw        (sw),
    .bus       (bus),
    .disp_value(disp_value),
    .disp_count(disp_count),
    .busy      (busy),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: result RAM with one cycle of read latency.
  logic [15:0] ram [RAM_WORDS];
  always @(posedge clk) bus.count <= ram[bus.n];

  // go pulse monitor, sampled mid-cycle.
  int   go_count  = 0;
  int   go_double = 0;
  logic go_prev   = 1'b0;
  always @(negedge clk) begin
    if (bus.go === 1'b1) begin
      go_count++;
      if (go_prev === 1'b1) go_double++;
    end
    go_prev = bus.go;
  end

  int checks = 0;
  int fails  = 0;
  int exp_n;
  int exp_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Hold the masked keys down, release, then let the release debounce.
  task automatic press(input logic [3:0] mask, input int hold);
    key_n = ~mask;
    tick(hold);
    key_n = 4'hF;
    tick(10);
  endtask

  task automatic wait_show(input string tag);
    int k;
    k = 0;
    while (valid !== 1'b1 && k < 40) begin
      tick(1);
      k++;
    end
    check(tag, {31'b0, valid}, 32'd1);
  endtask

  task automatic check_view(input string tag);
    $display("step %s: n=%0d disp_value=%0d disp_count=%0d", tag, bus.n, disp_value, disp_count);
    check({tag, "_n"},   {24'b0, bus.n},      exp_n);
    check({tag, "_val"}, {20'b0, disp_value}, (exp_start + exp_n) % 4096);
    check({tag, "_cnt"}, {16'b0, disp_count}, ram[exp_n]);
  endtask

  task automatic finish_run(input string tag);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    wait_show(tag);
  endtask

  task automatic launch(input int seed, input string tag);
    int g0;
    g0 = go_count;
    sw = 10'(seed);
    press(4'b0001, 10);
    check({tag, "_go"},    go_count, g0 + 1);
    check({tag, "_start"}, bus.start, seed);
    check({tag, "_busy"},  {31'b0, busy}, 32'd1);
    exp_start = seed;
    exp_n     = 0;
    tick(5);
    finish_run({tag, "_show"});
    check_view(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int r;
    int held;

    for (int i = 0; i < RAM_WORDS; i++) ram[i] = 16'($urandom);
    ram[0]   = 16'd111;
    bus.done = 1'b0;

    // ---- reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_go",    {31'b0, bus.go}, 0);
    check("rst_start", bus.start, 0);
    check("rst_n",     {24'b0, bus.n}, 0);
    check("rst_cnt",   {16'b0, disp_count}, 0);
    check("rst_busy",  {31'b0, busy}, 0);
    check("rst_valid", {31'b0, valid}, 0);

    // ---- launch with exact FETCH latency
    g0 = go_count;
    sw = 10'd27;
    press(4'b0001, 10);
    check("launch_go",    go_count, g0 + 1);
    check("launch_start", bus.start, 27);
    check("launch_busy",  {31'b0, busy}, 1);
    exp_start = 27;
    exp_n     = 0;
    tick(30);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    check("fetch_valid", {31'b0, valid}, 0);
    check("fetch_busy",  {31'b0, busy}, 1);
    tick(2);
    check("show_valid", {31'b0, valid}, 1);
    check_view("launch");

    // ---- debounce: 2-cycle chatter must not register, steady hold once
    for (int i = 0; i < 10; i++) begin
      key_n[1] = ~key_n[1];
      tick(2);
    end
    key_n[1] = 1'b0;
    tick(10);
    key_n = 4'hF;
    tick(10);
    exp_n = 1;
    check_view("debounce");
    tick(20);
    check_view("release");

    // ---- wrap both ways
    press(4'b1000, 10);
    wait_show("clr_show");
    exp_n = 0;
    check_view("clear");
    press(4'b0100, 10);
    wait_show("dec_show");
    exp_n = RAM_WORDS - 1;
    check_view("wrap_dec");
    check("wrap_val", {20'b0, disp_value}, 282);
    press(4'b0010, 10);
    wait_show("inc_show");
    exp_n = 0;
    check_view("wrap_inc");

    // ---- randomized browsing
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        press(4'b0010, 10);
        exp_n = (exp_n + 1) % RAM_WORDS;
      end else if (r <= 7) begin
        press(4'b0100, 10);
        exp_n = (exp_n + RAM_WORDS - 1) % RAM_WORDS;
      end else if (r == 8) begin
        press(4'b1000, 10);
        exp_n = 0;
      end else begin
        press(4'b1100, 10);   // clear beats dec
        exp_n = 0;
      end
      wait_show("rnd_show");
      check_view("rnd");
    end

    // ---- priority: go and inc together from a nonzero n
    press(4'b0010, 10);
    wait_show("pre_show");
    exp_n = (exp_n + 1) % RAM_WORDS;
    check_view("pre_prio");
    g0 = go_count;
    r  = $urandom_range(1, 1023);
    sw = 10'(r);
    press(4'b0011, 10);
    check("prio_go",    go_count, g0 + 1);
    check("prio_n",     {24'b0, bus.n}, 0);
    check("prio_busy",  {31'b0, busy}, 1);
    check("prio_start", bus.start, r);
    exp_start = r;
    exp_n     = 0;
    finish_run("prio_show");
    check_view("prio");

    // ---- events during RUN are dropped; reset aborts the run
    g0 = go_count;
    sw = 10'd700;
    press(4'b0001, 10);
    check("run_go", go_count, g0 + 1);
    press(4'b0010, 10);
    press(4'b1000, 10);
    check("run_n",     {24'b0, bus.n}, 0);
    check("run_busy",  {31'b0, busy}, 1);
    check("run_valid", {31'b0, valid}, 0);
    check("run_gocnt", go_count, g0 + 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    tick(5);
    check("abort_busy",  {31'b0, busy}, 0);
    check("abort_valid", {31'b0, valid}, 0);
    check("abort_go",    {31'b0, bus.go}, 0);
    check("abort_n",     {24'b0, bus.n}, 0);
    check("abort_start", bus.start, 0);
    check("abort_cnt",   {16'b0, disp_count}, 0);
    check("abort_gocnt", go_count, g0 + 1);

    // ---- relaunch after the abort
    launch(513, "relaunch");

`ifdef HOLD_REPEAT_EN
    // ---- auto-repeat: one press step plus one step at RPT_DLY and every
    // RPT_PER after that, for as long as the debounced key stays down.
    held  = 40;
    key_n = 4'b1101;
    tick(held);
    key_n = 4'hF;
    tick(14);
    exp_n = 1 + (held - RPT_DLY + RPT_PER - 1) / RPT_PER;
    check_view("repeat");
`else
    held = 0;
`endif

    check("go_double", go_double, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
